// File: rtl/hdr_video_pkg.sv
// Shared types and constants for the HDR video output stage: FSM states,
// FIFO word layout, black level, colour-bar table and default 640x480 timing.
package hdr_video_pkg;

    typedef enum logic [1:0] {SEARCH, FILL, LOCKED} state_t;

    typedef struct packed {
        logic        eof;
        logic [15:0] data;
    } fifo_word_t;

    localparam logic [7:0]  BLACK_Y   = 8'h10;
    localparam logic [7:0]  BLACK_C   = 8'h80;
    localparam logic [15:0] BLACK_PIX = {BLACK_Y, BLACK_C};

    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_H_FP        = 16;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_BP        = 48;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_V_FP        = 10;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_BP        = 33;
    localparam int DEF_FIFO_DEPTH  = 1024;
    localparam int DEF_START_LEVEL = 512;

    // 75% bars as {Y, Cb, Cr}: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [23:0] BAR_TBL [8] = '{
        24'hB48080, 24'hA22C8E, 24'h839C2C, 24'h70483A,
        24'h54B8C6, 24'h4164D4, 24'h23D472, 24'h108080
    };

    // Even columns carry Cb, odd columns Cr, matching the incoming 4:2:2 stream
    function automatic logic [15:0] bar_pixel(input int h, input int bar_w);
        int          idx;
        logic [23:0] e;
        idx = h / bar_w;
        if (idx > 7) idx = 7;
        e = BAR_TBL[idx];
        return {e[23:16], h[0] ? e[7:0] : e[15:8]};
    endfunction

endpackage

// File: rtl/hdr_sync_fifo.sv
// Single-clock line FIFO: registered read port, fill count, synchronous clear.
// head exposes the word at the read pointer so the caller can inspect it before popping.
module hdr_sync_fifo #(
    parameter int DEPTH = 1024,
    parameter int W     = 17
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [W-1:0]           wr_data,
    input  logic                   rd_en,
    output logic [W-1:0]           rd_data,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_wr, do_rd;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !clr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/hdr_video_out.sv
// HDMI-style output stage: raster timing, line FIFO and frame lock/resync FSM.
// Define HDR_VIDEO_OUT_TEST_PATTERN_EN to show colour bars instead of black while unlocked.
module hdr_video_out
    import hdr_video_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int START_LEVEL = DEF_START_LEVEL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        asi_snk_valid_i,
    output logic        asi_snk_ready_o,
    input  logic [15:0] asi_snk_data_i,
    input  logic        asi_snk_startofpacket_i,
    input  logic        asi_snk_endofpacket_i,
    output logic        data_enable,
    output logic        hsync,
    output logic        vsync,
    output logic [7:0]  data_Y,
    output logic [7:0]  data_Cb_Cr,
    output logic        frame_locked_o,
    output logic        underflow_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ALAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ALAST = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] START_C = CW'(START_LEVEL);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    state_t        state;
    fifo_word_t    wr_word, rd_word, head_word;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_full, fifo_empty;
    logic          active, last_px, frame_end, accept, fifo_wr, pop_try, resync, fifo_rd;
    logic          use_fifo;
    logic [15:0]   fill_pix, pix_q;
    logic          unused_bits;

    assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign last_px   = (h_cnt == H_ALAST) && (v_cnt == V_ALAST);
    assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

    assign asi_snk_ready_o = (state == SEARCH) || !fifo_full;
    assign accept  = asi_snk_valid_i && asi_snk_ready_o;
    assign fifo_wr = accept && ((state != SEARCH) || asi_snk_startofpacket_i);
    assign wr_word = '{eof: asi_snk_endofpacket_i, data: asi_snk_data_i};

    // eof must land exactly on the last active pixel; anything else means the stream slipped
    assign pop_try = (state == LOCKED) && active;
    assign resync  = pop_try && (fifo_empty || (head_word.eof != last_px));
    assign fifo_rd = pop_try && !resync;

`ifdef HDR_VIDEO_OUT_TEST_PATTERN_EN
    assign fill_pix = (state != LOCKED) ? bar_pixel(int'(h_cnt), BAR_W) : BLACK_PIX;
`else
    assign fill_pix = BLACK_PIX;
`endif

    hdr_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(17)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clr     (resync),
        .wr_en   (fifo_wr),
        .wr_data (wr_word),
        .rd_en   (fifo_rd),
        .rd_data (rd_word),
        .head    (head_word),
        .count   (fifo_cnt),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt          <= '0;
            v_cnt          <= '0;
            state          <= SEARCH;
            data_enable    <= 1'b0;
            hsync          <= 1'b0;
            vsync          <= 1'b0;
            frame_locked_o <= 1'b0;
            underflow_o    <= 1'b0;
            use_fifo       <= 1'b0;
            pix_q          <= BLACK_PIX;
        end else begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
            data_enable <= active;
            hsync       <= (h_cnt >= HS_BEG) && (h_cnt < HS_END);
            vsync       <= (v_cnt >= VS_BEG) && (v_cnt < VS_END);
            underflow_o <= resync;
            use_fifo    <= fifo_rd;
            pix_q       <= active ? fill_pix : BLACK_PIX;
            unique case (state)
                SEARCH: if (accept && asi_snk_startofpacket_i) state <= FILL;
                FILL: if (frame_end && fifo_cnt >= START_C) begin
                    state          <= LOCKED;
                    frame_locked_o <= 1'b1;
                end
                LOCKED: if (resync) begin
                    state          <= SEARCH;
                    frame_locked_o <= 1'b0;
                end
                default: state <= SEARCH;
            endcase
        end
    end

    // FIFO read data is already registered; select it on cycles that actually popped
    assign data_Y     = use_fifo ? rd_word.data[15:8] : pix_q[15:8];
    assign data_Cb_Cr = use_fifo ? rd_word.data[7:0]  : pix_q[7:0];

    assign unused_bits = ^{rd_word.eof, head_word.data};

endmodule

// File: tb/tb_hdr_video_out.sv
// Bench for hdr_video_out on a small 8x4 raster: frame scenarios from a table,
// randomized traffic against a queue-based model, mid-frame reset.
module tb_hdr_video_out;
    localparam int HA = 8, HFP = 2, HS = 2, HBP = 2;
    localparam int VA = 4, VFP = 1, VS = 1, VBP = 1;
    localparam int DEPTH = 16, START = 8;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int M_SEARCH = 0, M_FILL = 1, M_LOCKED = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid, sof, eof;
    logic [15:0] data;
    logic        ready, de, hs_o, vs_o, locked, uf;
    logic [7:0]  y, c;

    always #5 clk = ~clk;

    hdr_video_out #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .FIFO_DEPTH(DEPTH), .START_LEVEL(START)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .asi_snk_valid_i         (valid),
        .asi_snk_ready_o         (ready),
        .asi_snk_data_i          (data),
        .asi_snk_startofpacket_i (sof),
        .asi_snk_endofpacket_i   (eof),
        .data_enable             (de),
        .hsync                   (hs_o),
        .vsync                   (vs_o),
        .data_Y                  (y),
        .data_Cb_Cr              (c),
        .frame_locked_o          (locked),
        .underflow_o             (uf)
    );

    typedef struct packed { logic sof; logic eof; logic [15:0] data; } beat_t;
    typedef struct { int nfr; int npix; int eofi; int run; int exp_uf; logic exp_lk; } scen_t;

    int          errors = 0, checks = 0;
    beat_t       src[$];
    logic [16:0] mq[$];
    int          mode, th, tv, frame_no;
    logic        e_de, e_hs, e_vs, e_lk, e_uf;
    logic [7:0]  e_y, e_c;
    bit          pend, gaps, meas;
    int          uf_seen, m_de, m_hs, m_vs, m_hrise;
    logic        lk_seen, prev_hs;
    scen_t       tbl[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mode = M_SEARCH; mq.delete(); src.delete(); th = 0; tv = 0; pend = 0;
        valid = 0; sof = 0; eof = 0; data = '0;
        e_de = 0; e_hs = 0; e_vs = 0; e_lk = 0; e_uf = 0; e_y = 8'h10; e_c = 8'h80;
    endtask

    task automatic add_frame(input int npix, input int eofi, input bit rnd);
        beat_t b;
        for (int i = 0; i < npix; i++) begin
            b.sof  = (i == 0);
            b.eof  = (i == eofi);
            b.data = {8'(frame_no + 1), rnd ? 8'($urandom) : 8'(i)};
            src.push_back(b);
        end
        frame_no++;
    endtask

    // One clock: compare outputs at negedge, drive the next beat, predict the next edge
    task automatic cycle();
        logic rdy, acc, act, last, rs;
        logic [16:0] w;
        logic [15:0] pix;
        int sz;
        @(negedge clk);
        sz  = mq.size();
        rdy = (mode == M_SEARCH) || (sz < DEPTH);
        check("outputs", {de, hs_o, vs_o, y, c, locked, uf, ready},
                         {e_de, e_hs, e_vs, e_y, e_c, e_lk, e_uf, rdy});
        if (uf) begin
            check("fifo_clr", 32'(dut.u_fifo.count), 0);
            uf_seen++;
        end
        lk_seen = locked;
        if (meas) begin
            m_de += int'(de); m_hs += int'(hs_o); m_vs += int'(vs_o);
            if (hs_o && !prev_hs) m_hrise++;
        end
        prev_hs = hs_o;
        if (!pend) begin
            if (src.size() > 0 && (!gaps || $urandom_range(0, 4) != 0)) begin
                valid = 1; sof = src[0].sof; eof = src[0].eof; data = src[0].data; pend = 1;
            end else begin
                valid = 0;
            end
        end
        act  = (th < HA) && (tv < VA);
        last = (th == HA - 1) && (tv == VA - 1);
        acc  = valid && rdy;
        e_de = act;
        e_hs = (th >= HA + HFP) && (th < HA + HFP + HS);
        e_vs = (tv >= VA + VFP) && (tv < VA + VFP + VS);
        pix  = 16'h1080;
        rs   = 0;
        if (mode == M_LOCKED && act) begin
            if (sz == 0) rs = 1;
            else begin
                w = mq[0];
                if (w[16] != last) rs = 1; else pix = w[15:0];
            end
        end
        e_uf = rs;
        if (rs) begin
            mq.delete(); mode = M_SEARCH;
        end else begin
            if (mode == M_LOCKED && act) void'(mq.pop_front());
            if (mode == M_SEARCH) begin
                if (acc && sof) begin mq.push_back({eof, data}); mode = M_FILL; end
            end else begin
                if (acc) mq.push_back({eof, data});
                if (mode == M_FILL && th == HT - 1 && tv == VT - 1 && sz >= START) mode = M_LOCKED;
            end
        end
        e_lk = (mode == M_LOCKED);
        e_y  = pix[15:8];
        e_c  = pix[7:0];
        if (acc) begin void'(src.pop_front()); pend = 0; end
        th++;
        if (th == HT) begin th = 0; tv = (tv + 1) % VT; end
    endtask

    task automatic run_scen(input int s, input bit do_meas);
        for (int f = 0; f < tbl[s].nfr; f++) add_frame(tbl[s].npix, tbl[s].eofi, 0);
        uf_seen = 0;
        for (int k = 0; k < tbl[s].run * FRAME; k++) begin
            meas = do_meas && (k >= (tbl[s].run - 1) * FRAME);
            cycle();
        end
        meas = 0;
        check($sformatf("scen%0d_underflows", s), uf_seen, tbl[s].exp_uf);
        check($sformatf("scen%0d_locked", s), 32'(lk_seen), 32'(tbl[s].exp_lk));
    endtask

    initial begin
        int  r;
        bit  found;
        // nominal lock; 20-pixel frame starves; relock; eof on pixel 15 of 32
        tbl[0] = '{3, 32, 31, 3, 0, 1'b1};
        tbl[1] = '{1, 20, -1, 2, 1, 1'b0};
        tbl[2] = '{3, 32, 31, 3, 0, 1'b1};
        tbl[3] = '{1, 32, 15, 2, 1, 1'b0};
        frame_no = 0; gaps = 0; meas = 0; prev_hs = 0;
        m_de = 0; m_hs = 0; m_vs = 0; m_hrise = 0; lk_seen = 0;
        reset = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {de, hs_o, vs_o, y, c, locked, uf, ready}, {3'b000, 8'h10, 8'h80, 3'b001});
        @(posedge clk);
        #1 reset = 0;

        for (int s = 0; s < 4; s++) run_scen(s, s == 0);
        check("de_per_frame", m_de, HA * VA);
        check("hsync_cycles", m_hs, VT * HS);
        check("hsync_pulses", m_hrise, VT);
        check("vsync_cycles", m_vs, VS * HT);

        gaps = 1;
        for (int k = 0; k < 1500; k++) begin
            if (src.size() < 40) begin
                r = int'($urandom_range(0, 9));
                if (r < 7)       add_frame(32, 31, 1);
                else if (r == 7) add_frame(int'($urandom_range(4, 31)), -1, 1);
                else if (r == 8) add_frame(32, int'($urandom_range(0, 30)), 1);
                else             add_frame(40, 39, 1);
            end
            cycle();
        end

        gaps = 0;
        for (int f = 0; f < 8; f++) add_frame(32, 31, 0);
        found = 0;
        for (int k = 0; k < 12 * FRAME; k++) begin
            cycle();
            if (e_lk && e_de) begin found = 1; break; end
        end
        check("lock_before_reset", 32'(found), 1);
        @(posedge clk);
        #1 reset = 1;
        #1;
        check("reset_midframe", {de, hs_o, vs_o, y, c, locked, uf}, {3'b000, 8'h10, 8'h80, 2'b00});
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 0;
        #1;
        check("ready_after_release", 32'(ready), 1);
        run_scen(0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hdr_video_out.md
# hdr_video_out

Output stage downstream of the HDR algorithm wrapper. Consumes the fused 16-bit Avalon-ST stream, as {Y, CbCr} with start/end-of-packet, and buffers it in a line FIFO. It generates HDMI-style raster timing and drives data_enable/hsync/vsync and 8-bit Y / Cb-Cr to the HDMI transmitter. It replaces the free-running test-pattern source. It locks the stream to the raster at frame boundaries and resynchronises on underflow or packet misalignment.

## Interface
- H_ACTIVE, 640: active pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48: horizontal porches and sync width, in clocks
- V_ACTIVE, 480: active lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33: vertical porches and sync width, in lines
- FIFO_DEPTH, 1024: entries, power of two
- START_LEVEL, 512: minimum FIFO fill required to lock at frame start
- clk  in  1  pixel/system clock
- reset  in  1  asynchronous, active-high
- asi_snk_valid_i  in  1  input beat valid
- asi_snk_ready_o  out  1  sink ready
- asi_snk_data_i  in  16  {Y[15:8], CbCr[7:0]}
- asi_snk_startofpacket_i  in  1  first pixel of frame
- asi_snk_endofpacket_i  in  1  last pixel of frame
- data_enable  out  1  active video
- hsync  out  1  active-high horizontal sync
- vsync  out  1  active-high vertical sync
- data_Y  out  8  luma
- data_Cb_Cr  out  8  chroma, 4:2:2 interleaved as received
- frame_locked_o  out  1  high while in LOCKED
- underflow_o  out  1  one-cycle pulse per resync event

## Operation
- Raster counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1) free-run from reset. Active region is h_cnt<H_ACTIVE && v_cnt<V_ACTIVE, followed by FP, SYNC, BP. H_TOTAL is H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined likewise.
- FIFO word is 17 bits, {eof, data}. A write occurs on valid && ready, except in SEARCH.
- SEARCH
  - ready=1 and beats are discarded.
  - An accepted beat with sof is written, including when eof is also set, and the state moves to FILL.
- FILL
  - ready = !full.
  - Moves to LOCKED on the last raster cycle (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1) if fill ≥ START_LEVEL. Otherwise it waits for the next frame.
- LOCKED
  - ready = !full.
  - Each active-region cycle pops one word.
  - If the FIFO is empty on an active cycle, the pixel is output as black (Y=0x10, CbCr=0x80) and a resync occurs.
  - If the popped eof bit is set on any pixel other than the last active pixel, or clear on the last active pixel, a resync occurs.
- Resync
  - The FIFO is cleared synchronously.
  - underflow_o pulses for one cycle and the state moves to SEARCH.
  - The raster continues uninterrupted.
- Outside LOCKED, active pixels are black.
- A simultaneous push and pop leaves the fill count unchanged. A pop on the same cycle as a resync is discarded.

## Timing
- Outputs are registered and appear 1 cycle after the counter state that produced them. FIFO read data is registered, 1-cycle read, so data aligns with data_enable.
- Reset values:
  - data_enable, hsync, vsync, frame_locked_o, underflow_o: 0
  - data_Y: 0x10
  - data_Cb_Cr: 0x80
  - FIFO: empty
  - state: SEARCH
  - counters: 0
- asi_snk_ready_o is combinational from state and full. Upstream may hold valid across low-ready cycles.
- Reset asserted mid-frame aborts everything immediately. After release, the first sof accepted starts FILL.
- The first locked pixel appears on data_Y 1 cycle after raster (0,0).

## Configuration
- HDR_VIDEO_OUT_TEST_PATTERN_EN
  - Defined: outside LOCKED, active pixels show 8 vertical colour bars of width H_ACTIVE/8, as YCbCr 4:2:2, instead of black. A resynced pixel in LOCKED still outputs black.
  - Undefined: the bar logic is absent and non-locked video is black.

## Structure
- Package hdr_video_pkg: state enum (SEARCH, FILL, LOCKED); black constants (0x10, 0x80); colour-bar table; default timing constants.
- Sub-module hdr_sync_fifo: single-clock FIFO, 17-bit width, registered read, count output, synchronous clear.
- Counters, FSM and output registers live in hdr_video_out.

## Test plan
- Reset: assert mid-operation. All outputs reach their reset values within the same cycle, and ready=1 after release.
- Nominal frame: H_ACTIVE=8, V_ACTIVE=4, porches 2/2/2 and 1/1/1, START_LEVEL=8. Send 32 pixels data=0x0100+i with sof at i=0 and eof at i=31. The next frame outputs data_Y=0x01, data_Cb_Cr=i in order, and frame_locked_o=1.
- Underflow: lock as above, then stop input after 20 pixels. Pixel 20 is black, underflow_o pulses once, frame_locked_o=0, and relock occurs on the next sof.
- Misaligned eof: send eof on pixel 15 of 32. underflow_o pulses when pixel 15 is output, and the FIFO is empty on the following cycle.
- Backpressure: FIFO_DEPTH=16 with continuous valid in FILL. ready drops at count 16, no beat is lost or duplicated, and output order is preserved.
- Sync: verify hsync width H_SYNC, vsync width V_SYNC lines, and data_enable count per frame = H_ACTIVE·V_ACTIVE.
